gate_bist_ctrl: RTL and testbench
=================================

GATE_BIST_CTRL -- requirements
Module: gate_bist_ctrl

Interface
REQ-001 The block SHALL have parameter N_IN, default 19, giving the stimulus width driven into the gate model.
REQ-002 The block SHALL have parameter N_OUT, default 10, giving the response width read back from the gate model.
REQ-003 The block SHALL have parameter N_PAT, default 256, giving the number of patterns per run, legal range 1..65535.
REQ-004 The block SHALL have parameter SEED, default 19'h00001, giving the nonzero LFSR start value.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-007 The block SHALL have port start, input, 1 bit: a one-cycle request to begin a run.
REQ-008 The block SHALL have port abort, input, 1 bit: a request to cancel a run in progress.
REQ-009 The block SHALL have port golden_sig, input, N_OUT bits: the expected signature, sampled in DONE entry cycle.
REQ-010 The block SHALL have port resp, input, N_OUT bits: the gate model outputs (N95..N119 order, LSB first).
REQ-011 The block SHALL have port pattern, output, N_IN bits: the gate model inputs N1..N19, with N1 at the LSB.
REQ-012 The block SHALL have port signature, output, N_OUT bits: the MISR contents.
REQ-013 The block SHALL have port busy, output, 1 bit: high during SEED/RUN.
REQ-014 The block SHALL have port done, output, 1 bit: high in DONE.
REQ-015 The block SHALL have port pass, output, 1 bit: valid while done, high when signature==golden_sig.

Function
REQ-016 The FSM SHALL have states IDLE, SEED, RUN, DONE; IDLE-(start)->SEED->RUN-(count==N_PAT-1)->DONE-(start)->SEED.
REQ-017 In SEED (1 cycle), the block SHALL load pattern=SEED, signature=0, pattern counter=0.
REQ-018 In RUN, each cycle the block SHALL compact resp into the MISR, advance the LFSR, and increment the counter; exactly N_PAT responses are compacted.
REQ-019 The LFSR SHALL use the Fibonacci form next={pattern[17:0],fb}, where fb=pattern[18]^pattern[4]^pattern[1]^pattern[0] (maximal length 2^19-1).
REQ-020 The MISR SHALL compute next[0]=sig[9]^resp[0], next[3]=sig[2]^resp[3]^sig[9], and next[i]=sig[i-1]^resp[i] for all other i (x^10+x^3+1).
REQ-021 The gate model SHALL be treated as purely combinational: resp is sampled at the same edge that advances pattern, giving zero pipeline latency.
REQ-022 pass SHALL be registered on RUN->DONE using the final signature; pattern, signature and pass SHALL hold while in DONE.
REQ-023 start SHALL be ignored in SEED/RUN; abort in SEED/RUN SHALL go to IDLE with done=0 and pass=0; abort SHALL be ignored in IDLE/DONE.
REQ-024 When start and abort coincide in IDLE/DONE, start SHALL win; when they coincide in RUN, abort SHALL win.
REQ-025 With N_PAT=1, the block SHALL go SEED->RUN (1 cycle)->DONE.
REQ-026 The counter width SHALL be 16 bits, with no wrap inside a legal run.

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE, pattern=SEED, signature=0, counter=0, busy=0, done=0, pass=0, including mid-run.
REQ-028 After rst_n deasserts, the first start SHALL be accepted on the first rising edge.

Structure
REQ-029 Package gate_bist_pkg SHALL hold the state enum, the LFSR tap constants, the MISR polynomial constant, and the default widths.
REQ-030 The MISR SHALL be a separate sub-module gate_bist_misr (clk, rst_n, clr, en, resp, sig); the LFSR, counter and FSM SHALL stay in the top level.
REQ-031 The design SHALL be synthesizable with no latches and no combinational path from resp to any output.

Verification
REQ-032 SEED=1, N_PAT=4, resp=0: the pattern sequence in RUN SHALL be 0x00001, 0x00003, 0x00006, 0x0000D, ending with signature=0x000 and done=1.
REQ-033 N_PAT=2, resp=0x3FF constant: the signature SHALL be 0x3FF after the 1st RUN cycle and 0x008 at DONE; golden_sig=0x008 SHALL give pass=1, and 0x009 SHALL give pass=0.
REQ-034 Abort asserted on the 3rd RUN cycle: the next cycle SHALL be IDLE, with busy=0, done=0, and the following start restarting from SEED.
REQ-035 rst_n pulsed low mid-RUN: outputs SHALL change to reset values asynchronously before the next clk edge.
REQ-036 start pulsed during RUN SHALL give no restart and an unchanged total run length of N_PAT+1 cycles from SEED to DONE.
REQ-037 Gate model instance connected, N_PAT=256: two consecutive runs SHALL give identical signatures, and a stuck-at-0 injected on N116 SHALL cause pass=0.

Source files
------------

// File: rtl/gate_bist_pkg.sv
// gate_bist_pkg: shared state encoding, LFSR taps and MISR polynomial for the gate BIST controller.
package gate_bist_pkg;
    typedef enum logic [1:0] {st_idle, st_seed, st_run, st_done} state_t;
    localparam int n_in_def = 19;
    localparam int n_out_def = 10;
    localparam logic [18:0] lfsr_taps = 19'h40013;
    localparam logic [9:0] misr_poly = 10'h009;
endpackage

// File: rtl/gate_bist_misr.sv
// gate_bist_misr: multiple-input signature register compacting one response word per enabled cycle.
module gate_bist_misr import gate_bist_pkg::*; #(
    parameter int N_OUT = n_out_def,
    parameter logic [N_OUT-1:0] POLY = N_OUT'(misr_poly)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [N_OUT-1:0] resp,
    output logic [N_OUT-1:0] sig
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sig <= '0;
        else if (clr) sig <= '0;
        else if (en) sig <= {sig[N_OUT-2:0], 1'b0} ^ resp ^ (sig[N_OUT-1] ? POLY : '0);
endmodule

// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: LFSR pattern generator, pattern counter and run FSM driving a combinational gate model,
// with responses compacted into a MISR and compared against a golden signature.
module gate_bist_ctrl import gate_bist_pkg::*; #(
    parameter int N_IN = n_in_def,
    parameter int N_OUT = n_out_def,
    parameter int N_PAT = 256,
    parameter logic [N_IN-1:0] SEED = N_IN'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [N_OUT-1:0] golden_sig,
    input  logic [N_OUT-1:0] resp,
    output logic [N_IN-1:0]  pattern,
    output logic [N_OUT-1:0] signature,
    output logic             busy,
    output logic             done,
    output logic             pass
);
    localparam logic [N_IN-1:0] taps = N_IN'(lfsr_taps);
    localparam logic [N_OUT-1:0] poly = N_OUT'(misr_poly);
    localparam logic [15:0] last = 16'(N_PAT - 1);
    state_t state, nxt;
    logic [15:0] cnt;
    logic seed, run, fin;
    logic [N_OUT-1:0] sig_nxt;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= st_idle;
        else state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            st_idle: nxt = start ? st_seed : st_idle;
            st_seed: nxt = abort ? st_idle : st_run;
            st_run:  nxt = abort ? st_idle : (cnt == last ? st_done : st_run);
            st_done: nxt = start ? st_seed : st_done;
            default: nxt = st_idle;
        endcase
    end

    always_comb begin
        seed = state == st_seed;
        run = state == st_run;
        busy = seed || run;
        done = state == st_done;
        fin = run && nxt == st_done;
    end

    // The final compaction and the pass decision happen on the same edge, so compare against the MISR's next value.
    assign sig_nxt = {signature[N_OUT-2:0], 1'b0} ^ resp ^ (signature[N_OUT-1] ? poly : '0);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pattern <= SEED;
            cnt <= '0;
            pass <= 1'b0;
        end else begin
            if (seed) begin
                pattern <= SEED;
                cnt <= '0;
            end else if (run) begin
                pattern <= {pattern[N_IN-2:0], ^(pattern & taps)};
                cnt <= cnt + 16'd1;
            end
            pass <= fin ? sig_nxt == golden_sig : (nxt == st_done && pass);
        end

    gate_bist_misr #(.N_OUT(N_OUT), .POLY(poly)) u_misr (
        .clk(clk),
        .rst_n(rst_n),
        .clr(seed),
        .en(run),
        .resp(resp),
        .sig(signature)
    );
endmodule

// File: tb/tb_gate_bist_ctrl.sv
// tb_gate_bist_ctrl: directed checks of four controller instances (N_PAT = 4, 2, 256 with a gate model, 1).
module tb_gate_bist_ctrl;
    localparam int n116 = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] st = '0, ab = '0, busy, done, pass;
    logic [18:0] pat [4];
    logic [9:0] sig [4], resp [4], gold [4];
    logic [9:0] gm_resp, good_sig, bad_sig;
    logic fault = 1'b0;
    logic [18:0] exp_pat [4] = '{19'h00001, 19'h00003, 19'h00006, 19'h0000D};
    int total = 0, bad = 0, n;

    always #5 clk = ~clk;

    function automatic logic [9:0] gm(input logic [18:0] p);
        logic [9:0] r;
        for (int i = 0; i < 10; i++)
            r[i] = (p[i] & p[(i + 9) % 19]) ^ p[(i * 7 + 3) % 19] ^ (p[i + 1] | p[18 - i]);
        return r;
    endfunction

    function automatic logic [9:0] misr_step(input logic [9:0] s, input logic [9:0] r);
        return {s[8:0], s[9]} ^ r ^ {6'b0, s[9], 3'b0};
    endfunction

    function automatic logic [9:0] model_sig(input logic flt);
        logic [18:0] p = 19'h00001;
        logic [9:0] s = '0, r;
        for (int i = 0; i < 256; i++) begin
            r = gm(p) & ~(10'(flt) << n116);
            s = misr_step(s, r);
            p = {p[17:0], p[18] ^ p[4] ^ p[1] ^ p[0]};
        end
        return s;
    endfunction

    assign gm_resp = gm(pat[2]) & ~(10'(fault) << n116);

    for (genvar g = 0; g < 4; g++) begin : g_dut
        gate_bist_ctrl #(.N_PAT(g == 0 ? 4 : g == 1 ? 2 : g == 2 ? 256 : 1)) u_dut (
            .clk(clk),
            .rst_n(rst_n),
            .start(st[g]),
            .abort(ab[g]),
            .golden_sig(gold[g]),
            .resp(g == 2 ? gm_resp : resp[g]),
            .pattern(pat[g]),
            .signature(sig[g]),
            .busy(busy[g]),
            .done(done[g]),
            .pass(pass[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input int k);
        st[k] = 1'b1;
        tick();
        st[k] = 1'b0;
    endtask

    task automatic wait_done(input int k);
        int c = 0;
        while (!done[k] && c < 400) begin
            tick();
            c++;
        end
        check("done_wait", 32'(done[k]), 32'd1);
    endtask

    initial begin
        resp[0] = '0; resp[1] = 10'h3FF; resp[2] = '0; resp[3] = '0;
        gold[0] = '0; gold[1] = 10'h008; gold[3] = '0;
        good_sig = model_sig(1'b0);
        bad_sig = model_sig(1'b1);
        gold[2] = good_sig;
        repeat (2) tick();
        check("rst_pat", 32'(pat[0]), 32'h1);
        check("rst_sig", 32'(sig[1]), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_pass", 32'(pass), 32'h0);
        rst_n = 1'b1;
        kick(0);
        check("seed_busy", 32'(busy[0]), 32'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("run_pat", 32'(pat[0]), 32'(exp_pat[i]));
            tick();
        end
        check("p4_done", 32'(done[0]), 32'd1);
        check("p4_sig", 32'(sig[0]), 32'h0);
        check("p4_pass", 32'(pass[0]), 32'd1);
        check("p4_pat_end", 32'(pat[0]), 32'h1B);
        tick();
        check("p4_hold", 32'(pat[0]), 32'h1B);
        kick(0);
        n = 0;
        while (!done[0] && n < 20) begin
            st[0] = (n == 1);
            tick();
            n++;
        end
        st[0] = 1'b0;
        check("run_len", 32'(n), 32'd5);
        kick(0);
        tick();
        tick();
        st[0] = 1'b1;
        ab[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        ab[0] = 1'b0;
        check("abort_busy", 32'(busy[0]), 32'd0);
        check("abort_done", 32'(done[0]), 32'd0);
        check("abort_pass", 32'(pass[0]), 32'd0);
        tick();
        check("abort_idle", 32'(busy[0]), 32'd0);
        kick(0);
        check("restart_busy", 32'(busy[0]), 32'd1);
        tick();
        check("restart_pat", 32'(pat[0]), 32'h1);
        wait_done(0);
        check("restart_pass", 32'(pass[0]), 32'd1);
        ab[0] = 1'b1;
        tick();
        check("done_abort_ign", 32'(done[0]), 32'd1);
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        ab[0] = 1'b0;
        check("done_start_win", 32'(busy[0]), 32'd1);
        wait_done(0);
        kick(1);
        tick();
        tick();
        check("p2_sig1", 32'(sig[1]), 32'h3FF);
        tick();
        check("p2_done", 32'(done[1]), 32'd1);
        check("p2_sig", 32'(sig[1]), 32'h008);
        check("p2_pass", 32'(pass[1]), 32'd1);
        gold[1] = 10'h009;
        kick(1);
        wait_done(1);
        check("p2_sig_b", 32'(sig[1]), 32'h008);
        check("p2_fail", 32'(pass[1]), 32'd0);
        kick(3);
        tick();
        check("p1_run", 32'(busy[3]), 32'd1);
        check("p1_notdone", 32'(done[3]), 32'd0);
        tick();
        check("p1_done", 32'(done[3]), 32'd1);
        check("p1_pass", 32'(pass[3]), 32'd1);
        kick(1);
        tick();
        tick();
        check("pre_rst_sig", 32'(sig[1]), 32'h3FF);
        #2 rst_n = 1'b0;
        #1;
        check("arst_sig", 32'(sig[1]), 32'h0);
        check("arst_busy", 32'(busy[1]), 32'd0);
        check("arst_pat", 32'(pat[1]), 32'h1);
        check("arst_done", 32'(done), 32'h0);
        #2 rst_n = 1'b1;
        kick(1);
        check("first_start", 32'(busy[1]), 32'd1);
        wait_done(1);
        kick(2);
        wait_done(2);
        check("gm_sig1", 32'(sig[2]), 32'(good_sig));
        check("gm_pass1", 32'(pass[2]), 32'd1);
        kick(2);
        wait_done(2);
        check("gm_sig2", 32'(sig[2]), 32'(good_sig));
        check("gm_pass2", 32'(pass[2]), 32'd1);
        fault = 1'b1;
        kick(2);
        wait_done(2);
        check("gm_sig_sa0", 32'(sig[2]), 32'(bad_sig));
        check("gm_pass_sa0", 32'(pass[2]), 32'(bad_sig == good_sig));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
